// File: rtl/uart_line_buffer_if.sv
// uart_line_buffer_if: receiver-side byte strobe, transmitter handshake and
// status signals of the UART line buffer, grouped for port connection.
// master drives received bytes and the transmitter ready flag; slave is the
// line buffer itself.
interface uart_line_buffer_if #(
    parameter int ADDR_W = 6
);
    logic            din_valid;
    logic [7:0]      din;
    logic            tx_rdy;
    logic            tx_en;
    logic [7:0]      tx_data;
    logic            busy;
    logic            overflow;
    logic [ADDR_W:0] level;

    modport master (
        output din_valid, din, tx_rdy,
        input  tx_en, tx_data, busy, overflow, level
    );

    modport slave (
        input  din_valid, din, tx_rdy,
        output tx_en, tx_data, busy, overflow, level
    );
endinterface

// File: rtl/uart_line_buffer.sv
// uart_line_buffer: collects received bytes into a line and replays the whole
// line to the UART transmitter, one byte per transmitter handshake.
// A line ends on TERM_CHAR (stored and echoed) or when DEPTH bytes are held.
// Bytes arriving while a line drains are discarded and flag a sticky overflow.
// Optional build macro UART_LINE_BACKSPACE_EN: 8'h08 / 8'h7F erase the last
// stored byte instead of being stored.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_FILL | accepting bytes into the line buffer
// ST_SEND | draining; waiting for tx_rdy to load the next byte
// ST_ACK  | byte loaded; waiting for tx_rdy low (transmitter took it)
module uart_line_buffer #(
    parameter int         DEPTH     = 64,
    parameter int         ADDR_W    = 6,
    parameter logic [7:0] TERM_CHAR = 8'h0D
) (
    input logic clk,
    input logic rst,
    uart_line_buffer_if.slave bus
);

    localparam logic [ADDR_W:0] LEVEL_FULL = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_FILL = 2'd0,
        ST_SEND = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   level;
    logic [ADDR_W:0]   level_inc;
    logic              tx_en_q;
    logic [7:0]        tx_data_q;
    logic              overflow_q;

    logic wr_en;
    logic bs_en;
    logic send_en;
    logic clear_en;
    logic drop_en;
    logic is_term;

    assign level_inc = level + 1'b1;
    assign is_term   = (bus.din == TERM_CHAR);

`ifdef UART_LINE_BACKSPACE_EN
    logic is_bs;
    assign is_bs = (bus.din == 8'h08) || (bus.din == 8'h7F);
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_FILL;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and one-cycle datapath strobes.
    always_comb begin
        state_next = state;
        wr_en      = 1'b0;
        bs_en      = 1'b0;
        send_en    = 1'b0;
        clear_en   = 1'b0;
        drop_en    = 1'b0;
        case (state)
            ST_FILL: begin
                if (bus.din_valid) begin
`ifdef UART_LINE_BACKSPACE_EN
                    if (is_bs) begin
                        bs_en = (level != '0);
                    end else begin
                        wr_en = 1'b1;
                        if (is_term || (level_inc == LEVEL_FULL)) begin
                            state_next = ST_SEND;
                        end
                    end
`else
                    wr_en = 1'b1;
                    if (is_term || (level_inc == LEVEL_FULL)) begin
                        state_next = ST_SEND;
                    end
`endif
                end
            end
            ST_SEND: begin
                drop_en = bus.din_valid;
                if (bus.tx_rdy) begin
                    send_en    = 1'b1;
                    state_next = ST_ACK;
                end
            end
            ST_ACK: begin
                drop_en = bus.din_valid;
                if (!bus.tx_rdy) begin
                    // rd_ptr has already advanced past the byte just loaded.
                    if (rd_ptr == wr_ptr) begin
                        clear_en   = 1'b1;
                        state_next = ST_FILL;
                    end else begin
                        state_next = ST_SEND;
                    end
                end
            end
            default: begin
                state_next = ST_FILL;
            end
        endcase
    end

    // Line storage; no reset needed, validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= bus.din;
        end
    end

    // Pointers and fill level; a completed drain rewinds everything to 0.
    always_ff @(posedge clk) begin
        if (rst || clear_en) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
                level  <= level_inc;
            end
            if (bs_en) begin
                wr_ptr <= wr_ptr - 1'b1;
                level  <= level - 1'b1;
            end
            if (send_en) begin
                rd_ptr <= rd_ptr + 1'b1;
                level  <= level - 1'b1;
            end
        end
    end

    // Transmitter load strobe and registered byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_en_q   <= 1'b0;
            tx_data_q <= 8'h00;
        end else begin
            tx_en_q <= send_en;
            if (send_en) begin
                tx_data_q <= mem[rd_ptr];
            end
        end
    end

    // Sticky drop flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q <= 1'b0;
        end else if (drop_en) begin
            overflow_q <= 1'b1;
        end
    end

    assign bus.tx_en    = tx_en_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.busy     = (state != ST_FILL);
    assign bus.overflow = overflow_q;
    assign bus.level    = level;

endmodule

// File: tb/tb_uart_line_buffer.sv
// tb_uart_line_buffer: directed and randomized line traffic against a
// queue-based model of line collection and echo, with a transmitter model
// that goes busy for a programmable number of cycles per loaded byte.
module tb_uart_line_buffer;

    localparam int         DEPTH  = 64;
    localparam int         ADDR_W = 6;
    localparam logic [7:0] TERM   = 8'h0D;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    uart_line_buffer_if #(.ADDR_W(ADDR_W)) bus ();

    uart_line_buffer #(
        .DEPTH    (DEPTH),
        .ADDR_W   (ADDR_W),
        .TERM_CHAR(TERM)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    // reference model: current line and bytes still owed to the transmitter
    logic [7:0] line_q[$];
    logic [7:0] exp_q[$];
    bit         m_draining = 1'b0;
    bit         exp_ovf    = 1'b0;

    // transmitter model
    int   tx_busy_len = 10;
    bit   stall       = 1'b0;
    int   tx_cnt      = 0;
    int   tx_total    = 0;
    int   cyc         = 0;
    int   rise_cyc    = 0;
    int   last_tx_cyc = 0;
    logic prev_tx_en  = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            bus.tx_rdy = 1'b1;
            tx_cnt     = 0;
        end else if (bus.tx_en) begin
            check_val("tx_en_rdy", bus.tx_rdy, 1);
            check_val("tx_en_pulse", prev_tx_en, 0);
            if (exp_q.size() > 0) check_val("tx_data", bus.tx_data, exp_q.pop_front());
            else check_val("tx_extra", bus.tx_data, 32'h100);
            tx_total++;
            last_tx_cyc = cyc;
            bus.tx_rdy  = 1'b0;
            tx_cnt      = tx_busy_len;
        end else begin
            if (tx_cnt > 0) tx_cnt--;
            if (!bus.tx_rdy && tx_cnt == 0 && !stall) begin
                bus.tx_rdy = 1'b1;
                rise_cyc   = cyc;
            end else if (stall) begin
                bus.tx_rdy = 1'b0;
            end
        end
        prev_tx_en = bus.tx_en;
    end

    function automatic logic [7:0] rand_data();
        logic [7:0] v;
        v = 8'($urandom_range(0, 255));
        if (v == TERM) v = 8'h20;
        if ($urandom_range(0, 9) == 0) v = ($urandom_range(0, 1) == 0) ? 8'h08 : 8'h7F;
        return v;
    endfunction

    // apply one received byte to the model; called once its edge has passed
    task automatic model_rx(input logic [7:0] b);
        if (m_draining) begin
            exp_ovf = 1'b1;
            return;
        end
`ifdef UART_LINE_BACKSPACE_EN
        if (b == 8'h08 || b == 8'h7F) begin
            if (line_q.size() > 0) void'(line_q.pop_back());
            check_val("level_bs", bus.level, line_q.size());
            check_val("busy_bs", bus.busy, 0);
            return;
        end
`endif
        line_q.push_back(b);
        check_val("level", bus.level, line_q.size());
        if (b == TERM || line_q.size() == DEPTH) begin
            foreach (line_q[i]) exp_q.push_back(line_q[i]);
            line_q.delete();
            m_draining = 1'b1;
            check_val("busy_flush", bus.busy, 1);
        end else begin
            check_val("busy_fill", bus.busy, 0);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.din       = b;
        bus.din_valid = 1'b1;
        @(negedge clk);
        bus.din_valid = 1'b0;
        model_rx(b);
    endtask

    task automatic wait_drain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 3000 && !done; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !bus.busy) done = 1'b1;
        end
        check_val("drain_done", done, 1);
        m_draining = 1'b0;
        check_val("level_after", bus.level, 0);
        check_val("overflow", bus.overflow, exp_ovf);
        check_val("busy_after", bus.busy, 0);
    endtask

    task automatic check_reset_values();
        check_val("rst_tx_en", bus.tx_en, 0);
        check_val("rst_tx_data", bus.tx_data, 0);
        check_val("rst_busy", bus.busy, 0);
        check_val("rst_overflow", bus.overflow, 0);
        check_val("rst_level", bus.level, 0);
    endtask

    initial begin
        int base;
        int mode;
        int len;
        bit seen;

        rst           = 1'b1;
        bus.din_valid = 1'b0;
        bus.din       = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_reset_values();

        // basic line with 2-cycle latency to the first load
        tx_busy_len = 10;
        send_byte(8'h41);
        send_byte(8'h42);
        send_byte(TERM);
        @(negedge clk);
        check_val("first_tx_lat", bus.tx_en, 1);
        wait_drain();

        // backspace handling (model follows the build macro)
        send_byte(8'h41);
        send_byte(8'h58);
        send_byte(8'h08);
        send_byte(8'h42);
        send_byte(TERM);
        wait_drain();

        // terminator lands as the DEPTH-th byte: one drain, no overflow
        for (int i = 0; i < DEPTH - 1; i++) send_byte(8'h30 + 8'(i % 32));
        send_byte(TERM);
        wait_drain();

        // stalled transmitter
        stall = 1'b1;
        repeat (2) @(negedge clk);
        send_byte(8'h31);
        send_byte(8'h32);
        send_byte(TERM);
        base = tx_total;
        repeat (100) @(negedge clk);
        check_val("stall_no_tx", tx_total, base);
        stall = 1'b0;
        seen  = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (tx_total != base) seen = 1'b1;
        end
        check_val("stall_seen", seen, 1);
        check_val("stall_lat", last_tx_cyc - rise_cyc, 1);
        wait_drain();

        // forced flush plus a byte dropped while draining
        for (int i = 0; i < DEPTH; i++) send_byte(8'h30 + 8'(i % 32));
        send_byte(8'h35);
        wait_drain();

        // randomized lines, transmitter speeds and drop strobes
        for (int ln = 0; ln < 25; ln++) begin
            mode        = $urandom_range(0, 5);
            tx_busy_len = $urandom_range(1, 12);
            if (mode == 0) begin
                for (int k = 0; k < 300 && !m_draining; k++) send_byte(rand_data());
            end else begin
                len = $urandom_range(0, 20);
                for (int k = 0; k < len; k++) begin
                    send_byte(rand_data());
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                end
                send_byte(TERM);
            end
            if ($urandom_range(0, 3) == 0) send_byte(rand_data());
            wait_drain();
        end

        // reset after the 2nd load of a 5-byte line
        tx_busy_len = 10;
        base = tx_total;
        send_byte(8'h51);
        send_byte(8'h52);
        send_byte(8'h53);
        send_byte(8'h54);
        send_byte(TERM);
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (tx_total >= base + 2) seen = 1'b1;
        end
        check_val("mid_drain_seen", seen, 1);
        rst = 1'b1;
        exp_q.delete();
        line_q.delete();
        m_draining = 1'b0;
        exp_ovf    = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check_reset_values();
        base = tx_total;
        send_byte(8'h41);
        send_byte(TERM);
        wait_drain();
        check_val("post_rst_count", tx_total - base, 2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
